// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter: round-robin arbiter sharing one synchronous RAM port among N_REQ requesters.
// Accesses are issued through registered mem_* outputs; responses are routed back two cycles after grant.
module mem_rr_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int N_REQ      = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ-1:0]            req_valid,
    output logic [N_REQ-1:0]            req_ready,
    input  logic [N_REQ-1:0]            req_we,
    input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [N_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]       rsp_rdata,
    output logic                        mem_en,
    output logic                        mem_we,
    output logic [ADDR_WIDTH-1:0]       mem_addr,
    output logic [DATA_WIDTH-1:0]       mem_wdata,
    input  logic [DATA_WIDTH-1:0]       mem_rdata
);
    localparam int PW = $clog2(N_REQ);
    localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

    logic [PW-1:0] r_last;
    logic [PW-1:0] r_own_a;
    logic [PW-1:0] r_own_b;
    logic          r_vld_b;
    logic          r_we_b;
    logic [PW-1:0] w_cand;
    logic [PW-1:0] w_idx;
    logic          w_found;

    // Scan starts just after the last winner so every requester gets a turn.
    always_comb begin
        w_found = 1'b0;
        w_idx   = r_last;
        w_cand  = r_last;
        for (int k = 1; k <= N_REQ; k++) begin
            w_cand = PW'((int'(r_last) + k) % N_REQ);
            if (!w_found && req_valid[w_cand]) begin
                w_found = 1'b1;
                w_idx   = w_cand;
            end
        end
    end

    assign req_ready = (rst_n && w_found) ? ONE << w_idx : '0;

    // Stage A of the response tag is mem_en/mem_we/r_own_a; stage B follows one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            r_last    <= PW'(N_REQ - 1);
            r_own_a   <= '0;
            r_own_b   <= '0;
            r_vld_b   <= 1'b0;
            r_we_b    <= 1'b0;
        end else begin
            mem_en  <= w_found;
            r_vld_b <= mem_en;
            r_own_b <= r_own_a;
            r_we_b  <= mem_we;
            if (w_found) begin
                mem_we    <= req_we[w_idx];
                mem_addr  <= req_addr[w_idx*ADDR_WIDTH +: ADDR_WIDTH];
                mem_wdata <= req_wdata[w_idx*DATA_WIDTH +: DATA_WIDTH];
                r_last    <= w_idx;
                r_own_a   <= w_idx;
            end
        end
    end

    assign rsp_valid = r_vld_b ? ONE << r_own_b : '0;
    assign rsp_rdata = (r_vld_b && !r_we_b) ? mem_rdata : '0;
endmodule
